branch_pc_sequencer: RTL

//  Owns the fetch PC and sequences instruction-memory requests for the core front end.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/branch_pc_sequencer_brcond.sv | 29 ++
 rtl/branch_pc_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer and its branch condition unit.
package pc_seq_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BROP_W = 5;

  // BrOp field positions
  localparam int unsigned BR_JAL  = 4;
  localparam int unsigned BR_COND = 3;

  // funct3 codes for conditional branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    REQ   = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/branch_pc_sequencer_brcond.sv
// Branch condition unit: decides whether a resolved control instruction redirects the PC.
module branch_pc_sequencer_brcond
  import pc_seq_pkg::*;
(
  input  logic signed [XLEN-1:0]   RFrs1,
  input  logic signed [XLEN-1:0]   RFrs2,
  input  logic        [BROP_W-1:0] BrOp,
  output logic                     NextPCSrc
);

  logic cond_hit;

  // Undefined funct3 codes never take
  always_comb begin
    cond_hit = 1'b0;
    case (BrOp[2:0])
      F3_BEQ:  cond_hit = (RFrs1 == RFrs2);
      F3_BNE:  cond_hit = (RFrs1 != RFrs2);
      F3_BLT:  cond_hit = (RFrs1 < RFrs2);
      F3_BGE:  cond_hit = (RFrs1 >= RFrs2);
      F3_BLTU: cond_hit = ($unsigned(RFrs1) < $unsigned(RFrs2));
      F3_BGEU: cond_hit = ($unsigned(RFrs1) >= $unsigned(RFrs2));
      default: cond_hit = 1'b0;
    endcase
  end

  assign NextPCSrc = BrOp[BR_JAL] | (BrOp[BR_COND] & cond_hit);

endmodule

// File: rtl/branch_pc_sequencer.sv
// Fetch PC owner: sequences imem requests, applies taken redirects, drains in-flight fetches.
module branch_pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Stall,
  input  logic                     ExValid,
  input  logic        [BROP_W-1:0] BrOp,
  input  logic signed [XLEN-1:0]   RFrs1,
  input  logic signed [XLEN-1:0]   RFrs2,
  input  logic        [XLEN-1:0]   BrTarget,
  input  logic                     ImemReady,
  output logic                     ImemReq,
  output logic        [XLEN-1:0]   PC,
  output logic                     FetchValid,
  output logic                     Flush,
  output logic                     MisalignErr,
  output logic        [CNT_W-1:0]  TakenCnt
);

  seq_state_e             state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        saved_q, saved_d;
  logic                   req_q, req_d;
  logic                   fv_q, fv_d;
  logic                   flush_q, flush_d;
  logic                   mis_q, mis_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   next_pc_src;
  logic                   taken;
  logic                   tgt_misaligned;
  logic [XLEN-1:0]        eff_tgt;

  branch_pc_sequencer_brcond u_brcond (
    .RFrs1     (RFrs1),
    .RFrs2     (RFrs2),
    .BrOp      (BrOp),
    .NextPCSrc (next_pc_src)
  );

  assign taken          = ExValid & next_pc_src;
  assign tgt_misaligned = (BrTarget[1:0] != 2'b00);
  assign eff_tgt        = tgt_misaligned ? TRAP_VEC : BrTarget;

  // Next-state, PC, saved target and pulse outputs
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    saved_d = saved_q;
    fv_d    = 1'b0;
    flush_d = taken;
    mis_d   = taken & tgt_misaligned;
    cnt_d   = (taken && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    case (state_q)
      BOOT: begin
        state_d = IDLE;
        if (taken) pc_d = eff_tgt;
      end
      IDLE: begin
        if (taken)       pc_d    = eff_tgt;
        else if (!Stall) state_d = REQ;
      end
      REQ: begin
        if (ImemReady) begin
          if (taken) begin
            pc_d = eff_tgt;
          end else begin
            pc_d = pc_q + XLEN'(4);
            fv_d = 1'b1;
          end
          state_d = Stall ? IDLE : REQ;
        end else if (taken) begin
          saved_d = eff_tgt;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (taken) saved_d = eff_tgt;
        // A redirect arriving with the returning data wins over the older saved target
        if (ImemReady) begin
          pc_d    = taken ? eff_tgt : saved_q;
          state_d = IDLE;
        end
      end
      default: state_d = BOOT;
    endcase

    req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      saved_q <= '0;
      req_q   <= 1'b0;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
      req_q   <= req_d;
      fv_q    <= fv_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ImemReq     = req_q;
  assign PC          = pc_q;
  assign FetchValid  = fv_q;
  assign Flush       = flush_q;
  assign MisalignErr = mis_q;
  assign TakenCnt    = cnt_q;

endmodule
